scan_unload_deserializer: RTL

Receive-side endpoint of the encrypted scan path. Drives the chain's shift enable, collects the serial scan-out stream into WORD_W-bit words, removes the 128-bit key mask, and presents each word on a ready/valid port. Optionally folds every accepted word into a 32-bit integrity signature and compares it against an expected value. Sits between the last scan cell of a die's chain and the test-access/response logic.

---
 rtl/scan_pkg.sv | 27 ++
 rtl/scan_sig_misr.sv | 34 +++
 rtl/scan_unload_deserializer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// Shared definitions for the scan unload path: FSM states, default
// widths/polynomial, and the signature fold/update helpers.
package scan_pkg;

  localparam int          WORD_W_DEF   = 128;
  localparam logic [31:0] SIG_POLY_DEF = 32'h04C1_1DB7;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    DONE
  } state_t;

  // XOR the four 32-bit slices of an unmasked word together.
  function automatic logic [31:0] sig_fold(input logic [127:0] w);
    return w[31:0] ^ w[63:32] ^ w[95:64] ^ w[127:96];
  endfunction

  // One signature step: shift left, apply polynomial feedback, then fold in the word.
  function automatic logic [31:0] sig_update(input logic [31:0]  sig,
                                             input logic [127:0] w,
                                             input logic [31:0]  poly);
    return {sig[30:0], 1'b0} ^ (sig[31] ? poly : 32'h0) ^ sig_fold(w);
  endfunction

endpackage

// File: rtl/scan_sig_misr.sv
// 32-bit integrity signature register. It is cleared at the start of an
// unload and updated once per accepted word. At the end of the unload it
// latches a mismatch flag by comparing against the expected value.
module scan_sig_misr
  import scan_pkg::*;
#(
  parameter logic [31:0] POLY = SIG_POLY_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         update,
  input  logic [127:0] word,
  input  logic         check,
  input  logic [31:0]  exp_sig,
  output logic [31:0]  sig,
  output logic         err
);

  // Signature and error flag; clear has priority, and update/check never coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      sig <= '0;
      err <= 1'b0;
    end else if (clear) begin
      sig <= '0;
      err <= 1'b0;
    end else begin
      if (update) sig <= sig_update(sig, word, POLY);
      if (check)  err <= (sig != exp_sig);
    end
  end

endmodule

// File: rtl/scan_unload_deserializer.sv
// Receive endpoint of the encrypted scan path. It drives shift_en and
// collects scan-out bits LSB-first into words. Each word is unmasked with
// key and handed out on a ready/valid port.
// Optional feature macro SCAN_SIG_EN adds the integrity signature (sig_out/sig_err).
module scan_unload_deserializer
  import scan_pkg::*;
#(
  parameter int          WORD_W   = WORD_W_DEF,
  parameter int          CNT_W    = 8,
  parameter logic [31:0] SIG_POLY = SIG_POLY_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  nwords,
  input  logic              so_in,
  output logic              shift_en,
  input  logic [WORD_W-1:0] key,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              done,
  input  logic [31:0]       exp_sig,
  output logic [31:0]       sig_out,
  output logic              sig_err
);

  localparam int BIT_W = $clog2(WORD_W);

  state_t             state, state_next;
  logic [BIT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   word_cnt;
  logic [CNT_W-1:0]   nwords_q;
  logic [WORD_W-2:0]  shreg;
  logic [WORD_W-1:0]  assembled;
  logic               start_ok;
  logic               last_bit;
  logic               accept;
  logic               last_word;

  assign start_ok  = (state == IDLE) && start;
  assign last_bit  = (bit_cnt == BIT_W'(WORD_W - 1));
  assign accept    = word_valid && word_ready;
  assign last_word = ((word_cnt + CNT_W'(1)) == nwords_q);
  assign assembled = {so_in, shreg};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: shift a word, hold it until accepted, repeat until the count is reached.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = (nwords == '0) ? DONE : SHIFT;
      SHIFT: if (last_bit) state_next = HOLD;
      HOLD:  if (accept) state_next = last_word ? DONE : SHIFT;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs decoded from the state.
  always_comb begin
    shift_en = (state == SHIFT);
    busy     = (state != IDLE);
    done     = (state == DONE);
  end

  // Datapath: counters, right-shifting assembly register and the held output word.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt    <= '0;
      word_cnt   <= '0;
      nwords_q   <= '0;
      shreg      <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            nwords_q <= nwords;
            bit_cnt  <= '0;
            word_cnt <= '0;
          end
        end
        SHIFT: begin
          shreg   <= assembled[WORD_W-1:1];
          bit_cnt <= bit_cnt + BIT_W'(1);
          if (last_bit) begin
            bit_cnt    <= '0;
            word_out   <= assembled ^ key;
            word_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (accept) begin
            word_valid <= 1'b0;
            word_cnt   <= word_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SCAN_SIG_EN
  scan_sig_misr #(
    .POLY(SIG_POLY)
  ) u_misr (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_ok),
    .update (accept),
    .word   (word_out),
    .check  (state == DONE),
    .exp_sig(exp_sig),
    .sig    (sig_out),
    .err    (sig_err)
  );
`else
  logic unused_sig_cfg;
  assign unused_sig_cfg = ^{exp_sig, SIG_POLY};
  assign sig_out = '0;
  assign sig_err = 1'b0;
`endif

endmodule
